cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the instruction cache and the data cache.
- Sits between the two L1 caches and the burst/memory interface, below the pipeline's instr/data memory ports.
- Registered FSM that grants one requester at a time, latches the request, holds it to memory until `mem_resp`, then returns the line with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cacheline data width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_read  in  1  I-cache line read request (level, held until i_resp).
- i_addr  in  ADDR_W  I-cache line address (line-aligned).
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read command (held until mem_resp).
- mem_write  out  1  memory write command (held until mem_resp).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  LINE_W  memory write line.
- mem_rdata  in  LINE_W  memory read line, valid with mem_resp.
- mem_resp  in  1  memory completion, single-cycle pulse.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - All outputs 0, including i_rdata/d_rdata and mem_addr/mem_wdata.
  - Round-robin pointer = DATA.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE, no request pending: stay in IDLE; mem_read=mem_write=0.
- IDLE, request pending:
  - Arbiter picks a winner (see Optional Feature).
  - At the next edge: latch the winner's addr (and d_wdata, write flag) into mem_addr/mem_wdata registers.
  - Assert mem_read or mem_write; go to SERVE_I or SERVE_D.
  - Request seen in cycle N → memory command visible in cycle N+1.
- d_read and d_write both high: illegal; treated as a write.
- SERVE_x:
  - Command and latched addr/wdata held stable regardless of requester inputs.
  - A requester deasserting mid-transaction does not abort; the transaction completes.
  - mem_resp in cycle M:
    - Capture mem_rdata into x_rdata (reads only; writes leave it unchanged).
    - Drop mem_read/mem_write; pulse x_resp in cycle M+1; go to DONE.
- DONE:
  - One bubble cycle so the served cache can deassert its request.
  - No new grant in DONE; returns to IDLE in cycle M+2.
  - Minimum request-to-request spacing is 3 cycles plus memory latency.
- x_rdata holds its last value until the next read for that requester completes.
- mem_resp outside SERVE_x: ignored.
- At most one of mem_read/mem_write is high at any time; i_resp and d_resp are never high together.
- rst asserted mid-transaction:
  - Abandon the transaction; return to IDLE with outputs zeroed.
  - A mem_resp arriving later is ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous I and D requests in IDLE, grant the requester not served last.
  - Pointer updates on every grant; reset pointer = DATA, so the first contested grant goes to I.
- Undefined:
  - Fixed priority, D-cache always wins contested grants.
  - Pointer logic not instantiated.
- An uncontested request is granted immediately in both modes.

Decomposition:
- Shared package `arb_types`:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D, DONE}.
  - `arb_src_t` enum {SRC_INSTR, SRC_DATA}.
  - Localparam defaults for ADDR_W/LINE_W.
- Optional sub-module `arb_rr_pick`: combinational winner select plus registered last-grant pointer. Instantiated only under ARB_ROUND_ROBIN_EN.
- Otherwise a single module.

Test Plan:
- Lone I read:
  - Stimulus: i_read=1, i_addr=0x0000_0060, memory returns 0xA5… after 4 cycles.
  - Response: mem_read=1 with mem_addr=0x60 one cycle after request; i_resp pulses one cycle after mem_resp with i_rdata=0xA5…; d_resp stays 0.
- Lone D write:
  - Stimulus: d_write=1, d_addr=0x1000, d_wdata=0xDEAD….
  - Response: mem_write=1 with those values held stable until mem_resp; d_resp pulses once; d_rdata unchanged.
- Contest:
  - Stimulus: i_read and d_read both asserted in the same cycle, addresses 0x40 and 0x80.
  - Fixed mode: D served first (0x80), then I (0x40).
  - ARB_ROUND_ROBIN_EN: I first (0x40), then D.
- Requester drop:
  - Stimulus: d_read deasserted two cycles into SERVE_D, mem_addr=0x200.
  - Response: mem_read stays high with 0x200 until mem_resp; d_resp still pulses.
- Reset mid-transaction:
  - Stimulus: rst during SERVE_I, then mem_resp arrives one cycle after rst drops.
  - Response: all outputs 0, state IDLE, no i_resp pulse.
- Back-to-back:
  - Stimulus: d_read held continuously across 3 transactions.
  - Response: exactly one DONE bubble between each; mem_read low in each DONE cycle.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// rtl/cacheline_arbiter_pkg.sv - shared state/source enums and width defaults for cacheline_arbiter
package arb_types;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {SRC_INSTR, SRC_DATA} arb_src_t;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

endpackage

// File: rtl/cacheline_arbiter_rr_pick.sv
// rtl/cacheline_arbiter_rr_pick.sv - round-robin I/D winner select, used only with ARB_ROUND_ROBIN_EN
module arb_rr_pick
  import arb_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic pick_d
);

  arb_src_t last_q;
  arb_src_t last_d;

  // A contested grant goes to whoever was not served last.
  always_comb begin
    pick_d = d_req && (!i_req || (last_q == SRC_INSTR));
    last_d = last_q;
    if (grant_en && (i_req || d_req)) begin
      last_d = pick_d ? SRC_DATA : SRC_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_DATA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - shares one cacheline memory port between I-cache and D-cache
// Fixed D-priority by default; ARB_ROUND_ROBIN_EN selects round-robin on contested grants.
module cacheline_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic d_req;
  logic grant_en;
  logic pick_d;

  assign d_req    = d_read | d_write;
  assign grant_en = (state_q == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
  arb_rr_pick u_rr_pick (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_read),
    .d_req    (d_req),
    .grant_en (grant_en),
    .pick_d   (pick_d)
  );
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // d_read together with d_write is resolved as a writeback.
          if (pick_d) begin
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_write_q <= d_write;
            mem_read_q  <= ~d_write;
            state_q     <= SERVE_D;
          end else if (i_read) begin
            mem_addr_q  <= i_addr;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            state_q     <= SERVE_I;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            i_rdata_q  <= mem_rdata;
            mem_read_q <= 1'b0;
            i_resp_q   <= 1'b1;
            state_q    <= DONE;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            if (mem_read_q) begin
              d_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            d_resp_q    <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_rdata   = d_rdata_q;
  assign d_resp    = d_resp_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed self-checking bench for cacheline_arbiter (honours ARB_ROUND_ROBIN_EN)
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port (-1 none, 0 I, 1 D, 2 bubble) and what it asked for.
  int            owner = -1;
  int            last_src = 1;
  bit            model_ok = 0;
  bit            m_wr, m_ir, m_dr, dq, take_d;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_ird, m_drd;

  always @(posedge clk) begin
    m_ir = 0;
    m_dr = 0;
    if (rst) begin
      owner = -1; m_wr = 0; m_addr = '0; m_wdata = '0;
      m_ird = '0; m_drd = '0; last_src = 1; model_ok = 1;
    end else if (owner == 2) begin
      owner = -1;
    end else if (owner == -1) begin
      dq = d_read || d_write;
      if (i_read || dq) begin
`ifdef ARB_ROUND_ROBIN_EN
        take_d = dq && (!i_read || last_src == 0);
`else
        take_d = dq;
`endif
        last_src = take_d ? 1 : 0;
        owner    = take_d ? 1 : 0;
        m_wr     = take_d && d_write;
        m_addr   = take_d ? d_addr : i_addr;
        if (take_d) m_wdata = d_wdata;
      end
    end else if (mem_resp) begin
      if (owner == 0) begin
        m_ird = mem_rdata;
        m_ir  = 1;
      end else begin
        if (!m_wr) m_drd = mem_rdata;
        m_dr = 1;
      end
      owner = 2;
    end
  end

  bit exp_read, exp_write;
  always @(negedge clk) begin
    if (model_ok) begin
      exp_read  = (owner == 0) || (owner == 1 && !m_wr);
      exp_write = (owner == 1) && m_wr;
      chk("mem_read", LW'(mem_read), LW'(exp_read));
      chk("mem_write", LW'(mem_write), LW'(exp_write));
      chk("i_resp", LW'(i_resp), LW'(m_ir));
      chk("d_resp", LW'(d_resp), LW'(m_dr));
      chk("i_rdata", i_rdata, m_ird);
      chk("d_rdata", d_rdata, m_drd);
      if (exp_read || exp_write) chk("mem_addr", LW'(mem_addr), LW'(m_addr));
      if (exp_write) chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(input string nm);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    if (!(mem_read || mem_write)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no memory command within 20 cycles", nm);
    end
  endtask

  // Called in the cycle the command is first visible; returns in the cycle the resp pulse is visible.
  task automatic mem_reply(input int lat, input logic [LW-1:0] data);
    repeat (lat - 1) tick();
    mem_resp  = 1'b1;
    mem_rdata = data;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  logic [LW-1:0] pat_a5, pat_dead, pat_c3, pat_bb, pat_junk;
  logic [AW-1:0] first_addr, second_addr;
  int gap;

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_dead = {8{32'hDEADBEEF}};
    pat_c3   = {32{8'hC3}};
    pat_bb   = {16{16'hBB11}};
    pat_junk = {32{8'h77}};
`ifdef ARB_ROUND_ROBIN_EN
    first_addr = 32'h40; second_addr = 32'h80;
`else
    first_addr = 32'h80; second_addr = 32'h40;
`endif

    repeat (2) tick();
    chk("reset mem_read", LW'(mem_read), '0);
    chk("reset mem_addr", LW'(mem_addr), '0);
    chk("reset mem_wdata", mem_wdata, '0);
    chk("reset i_rdata", i_rdata, '0);
    rst = 1'b0;
    tick();

    // Lone I read
    i_read = 1'b1; i_addr = 32'h60;
    tick();
    chk("lone_i mem_read", LW'(mem_read), LW'(1'b1));
    chk("lone_i mem_addr", LW'(mem_addr), LW'(32'h60));
    mem_reply(4, pat_a5);
    chk("lone_i i_resp", LW'(i_resp), LW'(1'b1));
    chk("lone_i i_rdata", i_rdata, pat_a5);
    chk("lone_i d_resp", LW'(d_resp), '0);
    i_read = 1'b0;
    repeat (2) tick();

    // Lone D write
    d_write = 1'b1; d_addr = 32'h1000; d_wdata = pat_dead;
    tick();
    chk("lone_d mem_write", LW'(mem_write), LW'(1'b1));
    chk("lone_d mem_wdata", mem_wdata, pat_dead);
    d_wdata = '0; d_addr = 32'hFFFF_FFC0;
    mem_reply(3, pat_junk);
    chk("lone_d d_resp", LW'(d_resp), LW'(1'b1));
    chk("lone_d d_rdata", d_rdata, '0);
    d_write = 1'b0;
    repeat (2) tick();

    // Contest
    i_read = 1'b1; i_addr = 32'h40; d_read = 1'b1; d_addr = 32'h80;
    tick();
    chk("contest first addr", LW'(mem_addr), LW'(first_addr));
    mem_reply(2, pat_c3);
    if (first_addr == 32'h40) i_read = 1'b0; else d_read = 1'b0;
    wait_cmd("contest second");
    chk("contest second addr", LW'(mem_addr), LW'(second_addr));
    mem_reply(2, pat_bb);
    i_read = 1'b0; d_read = 1'b0;
    chk("contest i_rdata", i_rdata, (first_addr == 32'h40) ? pat_c3 : pat_bb);
    repeat (2) tick();

    // Requester drop mid-transaction
    d_read = 1'b1; d_addr = 32'h200;
    tick();
    repeat (2) tick();
    d_read = 1'b0; d_addr = '0;
    tick();
    chk("drop mem_read", LW'(mem_read), LW'(1'b1));
    chk("drop mem_addr", LW'(mem_addr), LW'(32'h200));
    mem_reply(2, pat_a5);
    chk("drop d_resp", LW'(d_resp), LW'(1'b1));
    chk("drop d_rdata", d_rdata, pat_a5);
    repeat (2) tick();

    // Reset mid-transaction
    i_read = 1'b1; i_addr = 32'h300;
    repeat (2) tick();
    rst = 1'b1; i_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst mem_read", LW'(mem_read), '0);
    chk("rst mem_addr", LW'(mem_addr), '0);
    chk("rst i_rdata", i_rdata, '0);
    chk("rst d_rdata", d_rdata, '0);
    tick();
    mem_resp = 1'b1; mem_rdata = pat_junk;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    chk("rst late i_resp", LW'(i_resp), '0);
    tick();
    chk("rst late i_resp2", LW'(i_resp), '0);
    chk("rst late i_rdata", i_rdata, '0);

    // Back-to-back D reads
    d_read = 1'b1; d_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      wait_cmd("b2b cmd");
      mem_reply(2, LW'(k + 5));
      chk("b2b d_rdata", d_rdata, LW'(k + 5));
      if (k == 2) begin
        d_read = 1'b0;
      end else begin
        gap = 0;
        while (!mem_read && gap < 20) begin
          gap++;
          tick();
        end
        chk("b2b gap", LW'(gap), LW'(2));
      end
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
